// File: rtl/simd_dispatch_if.sv
// Handshake bundle between simd_dispatch, its upstream/downstream and the lane units.
// The master side is the environment; the dispatcher takes the slave side.
interface simd_dispatch_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic [LANES-1:0]       in_mask;
  logic [LANES-1:0]       lane_valid;
  logic [LANES-1:0]       lane_pop;
  logic [LANES*WIDTH-1:0] lane_operand;
  logic [LANES-1:0]       lane_ready;
  logic [LANES-1:0]       lane_push;
  logic [LANES*WIDTH-1:0] lane_result;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_data;
  logic [LANES-1:0]       out_mask;

  modport master (
    output in_valid, in_data, in_mask, lane_pop, lane_push, lane_result, out_ready,
    input  in_ready, lane_valid, lane_operand, lane_ready, out_valid, out_data, out_mask
  );

  modport slave (
    input  in_valid, in_data, in_mask, lane_pop, lane_push, lane_result, out_ready,
    output in_ready, lane_valid, lane_operand, lane_ready, out_valid, out_data, out_mask
  );
endinterface

// File: rtl/simd_dispatch.sv
// Scatters one operand vector to per-lane units and gathers their results into one
// output vector; issue (pop) and collect (push) of all lanes overlap within RUN.
module simd_dispatch #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 4
) (
  input logic           clk,
  input logic           rst,
  simd_dispatch_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StOutput} state_e;

  state_e                 state_q, state_d;
  logic [LANES-1:0]       issue_q, issue_d;
  logic [LANES-1:0]       coll_q, coll_d;
  logic [LANES-1:0]       mask_q, mask_d;
  logic [LANES*WIDTH-1:0] operand_q, operand_d;
  logic [LANES*WIDTH-1:0] result_q, result_d;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    operand_d = operand_q;
    result_d  = result_q;
    // Pops/pushes only affect pending lanes, so applying them in every state is harmless.
    issue_d   = issue_q & ~bus.lane_pop;
    coll_d    = coll_q & ~bus.lane_push;
    for (int i = 0; i < int'(LANES); i++) begin
      if (bus.lane_push[i] && coll_q[i]) begin
        result_d[i*WIDTH +: WIDTH] = bus.lane_result[i*WIDTH +: WIDTH];
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          operand_d = bus.in_data;
          mask_d    = bus.in_mask;
          issue_d   = bus.in_mask;
          coll_d    = bus.in_mask;
          result_d  = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (coll_d == '0) state_d = StOutput;
      end
      StOutput: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      issue_q   <= '0;
      coll_q    <= '0;
      mask_q    <= '0;
      operand_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      issue_q   <= issue_d;
      coll_q    <= coll_d;
      mask_q    <= mask_d;
      operand_q <= operand_d;
      result_q  <= result_d;
    end
  end

  assign bus.in_ready     = (state_q == StIdle);
  assign bus.lane_valid   = issue_q;
  assign bus.lane_ready   = coll_q;
  assign bus.lane_operand = operand_q;
  assign bus.out_valid    = (state_q == StOutput);
  assign bus.out_data     = result_q;
  assign bus.out_mask     = mask_q;

endmodule
